// File: rtl/exp_series_engine.sv
// Iterative e^x evaluator: truncated Taylor series in unsigned Q8.8.
// Each term is the previous term times x, then times a LUT reciprocal of k.
module exp_series_engine #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [CNT_W-1:0] n_terms,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             ovf
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_MUL_X = 3'd2;
    localparam logic [2:0] S_MUL_R = 3'd3;
    localparam logic [2:0] S_ACC   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1 << FRAC);
    localparam int PROD_W = 2 * WIDTH - FRAC;

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [WIDTH-1:0] term_q, term_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CNT_W-1:0] k_q, k_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0]  recip;
    logic [WIDTH-1:0]  mul_b;
    logic [PROD_W-1:0] prod_sh;
    logic [WIDTH-1:0]  mul_res;
    logic [WIDTH-FRAC-1:0] mul_hi;
    logic [WIDTH:0]    add_full;
    logic [CNT_W-1:0]  k_inc;

    // Truncated Q8.8 of 256/k; k=0 never reaches the multiplier.
    always_comb begin
        case (k_q)
            4'd1:    recip = 16'h0100;
            4'd2:    recip = 16'h0080;
            4'd3:    recip = 16'h0055;
            4'd4:    recip = 16'h0040;
            4'd5:    recip = 16'h0033;
            4'd6:    recip = 16'h002A;
            4'd7:    recip = 16'h0024;
            4'd8:    recip = 16'h0020;
            4'd9:    recip = 16'h001C;
            4'd10:   recip = 16'h0019;
            4'd11:   recip = 16'h0017;
            4'd12:   recip = 16'h0015;
            4'd13:   recip = 16'h0013;
            4'd14:   recip = 16'h0012;
            4'd15:   recip = 16'h0011;
            default: recip = '0;
        endcase
    end

    // Shared multiplier: fractional LSBs are dropped before the result is named.
    always_comb begin
        mul_b   = (state_q == S_MUL_R) ? recip : x_q;
        prod_sh = PROD_W'(({{WIDTH{1'b0}}, term_q} * {{WIDTH{1'b0}}, mul_b}) >> FRAC);
        mul_res = prod_sh[WIDTH-1:0];
        mul_hi  = prod_sh[PROD_W-1:WIDTH];
    end

    always_comb begin
        add_full = {1'b0, sum_q} + {1'b0, term_q};
        k_inc    = k_q + 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        n_d      = n_q;
        term_d   = term_q;
        sum_d    = sum_q;
        result_d = result_q;
        k_d      = k_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = x;
                    n_d     = n_terms;
                    ovf_d   = 1'b0;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                term_d = ONE;
                k_d    = {{(CNT_W-1){1'b0}}, 1'b1};
                sum_d  = (n_q == '0) ? '0 : ONE;
                if (n_q <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    // result is loaded on entry to DONE so it is valid with the pulse
                    result_d = (n_q == '0) ? '0 : ONE;
                    state_d  = S_DONE;
                end else begin
                    state_d = S_MUL_X;
                end
            end
            S_MUL_X: begin
                term_d = mul_res;
                if (mul_hi != '0) ovf_d = 1'b1;
                state_d = S_MUL_R;
            end
            S_MUL_R: begin
                term_d = mul_res;
                if (mul_hi != '0) ovf_d = 1'b1;
                state_d = S_ACC;
            end
            S_ACC: begin
                sum_d = add_full[WIDTH-1:0];
                if (add_full[WIDTH]) ovf_d = 1'b1;
                k_d = k_inc;
                if (k_inc == n_q) begin
                    result_d = add_full[WIDTH-1:0];
                    state_d  = S_DONE;
                end else begin
                    state_d = S_MUL_X;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            n_q      <= '0;
            term_q   <= '0;
            sum_q    <= '0;
            result_q <= '0;
            k_q      <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            n_q      <= n_d;
            term_q   <= term_d;
            sum_q    <= sum_d;
            result_q <= result_d;
            k_q      <= k_d;
            ovf_q    <= ovf_d;
        end
    end

    assign result = result_q;
    assign done   = (state_q == S_DONE);
    assign busy   = (state_q != S_IDLE);
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_exp_series_engine.sv
// Self-checking bench for exp_series_engine against an arithmetic series model.
module tb_exp_series_engine;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] x_in;
    logic [3:0]  n_in;
    logic [15:0] result;
    logic        done;
    logic        busy;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    exp_series_engine #(.WIDTH(16), .FRAC(8), .CNT_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .x       (x_in),
        .n_terms (n_in),
        .result  (result),
        .done    (done),
        .busy    (busy),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Series sum straight from the math: term *= x, term *= floor(256/k), sum += term.
    function automatic void model(input int unsigned xv, input int unsigned nv,
                                  output logic [15:0] r, output logic o);
        longint unsigned term, sum, p;
        o = 1'b0;
        term = 256;
        sum = (nv == 0) ? 0 : 256;
        for (int unsigned k = 1; k < nv; k++) begin
            p = term * xv;
            if ((p >> 24) != 0) o = 1'b1;
            term = (p >> 8) & 64'hFFFF;
            p = term * (256 / k);
            if ((p >> 24) != 0) o = 1'b1;
            term = (p >> 8) & 64'hFFFF;
            sum = sum + term;
            if (sum > 64'hFFFF) o = 1'b1;
            sum = sum & 64'hFFFF;
        end
        r = sum[15:0];
    endfunction

    function automatic int exp_lat(input int unsigned nv);
        return (nv <= 1) ? 1 : 1 + 3 * (nv - 1);
    endfunction

    // Start one op, scramble inputs after acceptance, wait (bounded) for done.
    task automatic do_op(input logic [15:0] xv, input logic [3:0] nv,
                         output int lat, output logic [15:0] res, output logic o,
                         output logic busy0, output logic done2);
        @(negedge clk);
        start = 1'b1; x_in = xv; n_in = nv;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        x_in = 16'($urandom);
        n_in = 4'($urandom);
        busy0 = busy;
        lat = -1; res = '0; o = 1'b0; done2 = 1'b0;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = e; res = result; o = ovf;
                break;
            end
        end
        @(posedge clk);
        @(negedge clk);
        done2 = done;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; x_in = '0; n_in = '0;
        #3;
        checks++; if (result !== 16'h0000) begin errors++; $display("FAIL reset_result got=%h exp=0000", result); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat; logic [15:0] r; logic o, b0, d2;
        do_op(16'h0100, 4'd4, lat, r, o, b0, d2);
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", b0); end
        checks++; if (lat !== 10) begin errors++; $display("FAIL basic_latency got=%0d exp=10", lat); end
        checks++; if (r !== 16'h02AA) begin errors++; $display("FAIL basic_result got=%h exp=02aa", r); end
        checks++; if (o !== 1'b0) begin errors++; $display("FAIL basic_ovf got=%b exp=0", o); end
        checks++; if (d2 !== 1'b0) begin errors++; $display("FAIL basic_done_width got=%b exp=0", d2); end
    endtask

    task automatic test_zero_x();
        int lat; logic [15:0] r; logic o, b0, d2;
        do_op(16'h0000, 4'd5, lat, r, o, b0, d2);
        checks++; if (lat !== 13) begin errors++; $display("FAIL zero_x_latency got=%0d exp=13", lat); end
        checks++; if (r !== 16'h0100) begin errors++; $display("FAIL zero_x_result got=%h exp=0100", r); end
        checks++; if (o !== 1'b0) begin errors++; $display("FAIL zero_x_ovf got=%b exp=0", o); end
    endtask

    task automatic test_short();
        int lat; logic [15:0] r; logic o, b0, d2;
        do_op(16'h1234, 4'd1, lat, r, o, b0, d2);
        checks++; if (lat !== 1) begin errors++; $display("FAIL n1_latency got=%0d exp=1", lat); end
        checks++; if (r !== 16'h0100) begin errors++; $display("FAIL n1_result got=%h exp=0100", r); end
        do_op(16'h1234, 4'd0, lat, r, o, b0, d2);
        checks++; if (lat !== 1) begin errors++; $display("FAIL n0_latency got=%0d exp=1", lat); end
        checks++; if (r !== 16'h0000) begin errors++; $display("FAIL n0_result got=%h exp=0000", r); end
        checks++; if (o !== 1'b0) begin errors++; $display("FAIL n0_ovf got=%b exp=0", o); end
    endtask

    task automatic test_overflow();
        int lat; logic [15:0] r; logic o, b0, d2;
        do_op(16'h1000, 4'd3, lat, r, o, b0, d2);
        checks++; if (lat !== 7) begin errors++; $display("FAIL ovf_latency got=%0d exp=7", lat); end
        checks++; if (r !== 16'h1100) begin errors++; $display("FAIL ovf_result got=%h exp=1100", r); end
        checks++; if (o !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", o); end
        // a clean op afterwards must clear the sticky flag
        do_op(16'h0100, 4'd2, lat, r, o, b0, d2);
        checks++; if (o !== 1'b0) begin errors++; $display("FAIL ovf_cleared got=%b exp=0", o); end
        checks++; if (r !== 16'h0200) begin errors++; $display("FAIL ovf_next_result got=%h exp=0200", r); end
    endtask

    task automatic test_busy_start();
        int lat; int extra;
        logic [15:0] r;
        @(negedge clk);
        start = 1'b1; x_in = 16'h0100; n_in = 4'd4;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = -1; r = '0; extra = 0;
        for (int e = 1; e <= 60; e++) begin
            if (e == 4) begin start = 1'b1; x_in = 16'h0200; n_in = 4'd7; end
            if (e == 5) start = 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (done) begin lat = e; r = result; break; end
        end
        start = 1'b0;
        checks++; if (lat !== 10) begin errors++; $display("FAIL busy_start_latency got=%0d exp=10", lat); end
        checks++; if (r !== 16'h02AA) begin errors++; $display("FAIL busy_start_result got=%h exp=02aa", r); end
        for (int e = 0; e < 30; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (done || busy) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL busy_start_queued got=%0d exp=0", extra); end
    endtask

    task automatic test_done_start();
        int lat; int extra;
        @(negedge clk);
        start = 1'b1; x_in = 16'h0100; n_in = 4'd2;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = -1; extra = 0;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin lat = e; break; end
        end
        // start raised only for the DONE cycle
        start = 1'b1; x_in = 16'h0300; n_in = 4'd3;
        @(negedge clk);
        start = 1'b0;
        checks++; if (lat !== 4) begin errors++; $display("FAIL done_start_latency got=%0d exp=4", lat); end
        for (int e = 0; e < 6; e++) begin
            if (busy) extra++;
            @(negedge clk);
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL done_start_accepted got=%0d exp=0", extra); end
        checks++; if (result !== 16'h0200) begin errors++; $display("FAIL done_start_result got=%h exp=0200", result); end
    endtask

    task automatic test_result_hold();
        int bad;
        @(negedge clk);
        start = 1'b1; x_in = 16'h0180; n_in = 4'd6;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        bad = 0;
        for (int e = 1; e <= 14; e++) begin
            if (result !== 16'h0200) bad++;
            @(posedge clk);
            @(negedge clk);
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL result_hold changes=%0d exp=0", bad); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_mid_reset();
        int lat; logic [15:0] r, er; logic o, eo, b0, d2;
        @(negedge clk);
        start = 1'b1; x_in = 16'h0100; n_in = 4'd4;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++; if (result !== 16'h0000) begin errors++; $display("FAIL midrst_result got=%h exp=0000", result); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", done); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL midrst_ovf got=%b exp=0", ovf); end
        @(negedge clk);
        rst = 1'b0;
        do_op(16'h0180, 4'd6, lat, r, o, b0, d2);
        model(32'h0180, 6, er, eo);
        checks++; if (lat !== exp_lat(6)) begin errors++; $display("FAIL midrst_after_latency got=%0d exp=%0d", lat, exp_lat(6)); end
        checks++; if (r !== er) begin errors++; $display("FAIL midrst_after_result got=%h exp=%h", r, er); end
        checks++; if (o !== eo) begin errors++; $display("FAIL midrst_after_ovf got=%b exp=%b", o, eo); end
    endtask

    task automatic test_random();
        int lat; logic [15:0] r, er, xv; logic o, eo, b0, d2; logic [3:0] nv;
        for (int i = 0; i < 30; i++) begin
            xv = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h0300));
            nv = 4'($urandom_range(0, 15));
            do_op(xv, nv, lat, r, o, b0, d2);
            model(32'(xv), 32'(nv), er, eo);
            checks++; if (lat !== exp_lat(32'(nv))) begin errors++; $display("FAIL rand_latency x=%h n=%0d got=%0d exp=%0d", xv, nv, lat, exp_lat(32'(nv))); end
            checks++; if (r !== er) begin errors++; $display("FAIL rand_result x=%h n=%0d got=%h exp=%h", xv, nv, r, er); end
            checks++; if (o !== eo) begin errors++; $display("FAIL rand_ovf x=%h n=%0d got=%b exp=%b", xv, nv, o, eo); end
            checks++; if (d2 !== 1'b0) begin errors++; $display("FAIL rand_done_width x=%h n=%0d got=%b exp=0", xv, nv, d2); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_x();
        test_short();
        test_overflow();
        test_busy_start();
        test_done_start();
        test_result_hold();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exp_series_engine.md
Name: exp_series_engine

Overview:
- Iterative controller-plus-datapath that evaluates e^x as a truncated Taylor series, sum of x^k/k! for k = 0..n_terms-1, in unsigned Q8.8.
- Each term is derived from the previous one: term_k = (term_{k-1} * x) * recip(k).
- Reciprocals come from an internal constant LUT, so no divider is needed.
- Consumes the team's Q8.8 multiply (product bits [23:8]), add, 16-bit register and 4-bit counter primitives. Sits directly downstream of the operand source and feeds its result to the consumer.

Parameters:
- WIDTH, 16, data width. Q8.8 format.
- FRAC, 8, fractional bits. Multiply result is product[FRAC+WIDTH-1:FRAC].
- CNT_W, 4, term-counter width. n_terms max is 15.
- Only the defaults are supported; the reciprocal LUT is defined for them.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a computation. Sampled only in IDLE.
- x  in  16  operand, unsigned Q8.8. Latched when start is accepted.
- n_terms  in  4  number of series terms. Latched when start is accepted.
- result  out  16  series sum, unsigned Q8.8. Valid while done=1; held until the next accepted start.
- done  out  1  one-cycle pulse marking result valid.
- busy  out  1  high in every state except IDLE.
- ovf  out  1  sticky overflow flag for the current computation. Valid with done.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - result, term and x_reg = 0x0000; k=0; done=0; busy=0; ovf=0.
  - rst mid-operation aborts immediately with no done pulse.
- States: IDLE, INIT, MUL_X, MUL_R, ACC, DONE.
- IDLE:
  - On start=1, latch x and n_terms, clear ovf, go to INIT.
  - With start=0, stay in IDLE.
- INIT:
  - term <= 0x0100; k <= 1.
  - sum <= 0x0100, except sum <= 0x0000 if n_terms=0.
  - Go to DONE if n_terms <= 1, else go to MUL_X.
- MUL_X: term <= mul(term, x_reg); go to MUL_R.
- MUL_R: term <= mul(term, recip[k]); go to ACC.
- ACC:
  - sum <= sum + term, 16-bit wrap; k <= k+1.
  - Go to DONE if k+1 == n_terms, else go to MUL_X.
- DONE: done=1 for exactly this cycle; go to IDLE. result is the sum register.
- mul(a,b): 32-bit unsigned product, output bits [23:8], truncated (no rounding).
- ovf is set, and stays set, when any of the following occurs:
  - product bits [31:24] are nonzero in MUL_X or MUL_R;
  - the ACC add has a carry-out.
  - The wrapped values are still used; there is no saturation.
- recip[k], Q8.8 truncated of 256/k, for k = 1..15:
  - 1: 0x0100, 2: 0x0080, 3: 0x0055, 4: 0x0040, 5: 0x0033
  - 6: 0x002A, 7: 0x0024, 8: 0x0020, 9: 0x001C, 10: 0x0019
  - 11: 0x0017, 12: 0x0015, 13: 0x0013, 14: 0x0012, 15: 0x0011
- Latency: done is high in the cycle following edge number 1+3*max(n_terms-1,0), counting the start-sampling edge as edge 0.
  - n_terms=0 or 1: done follows edge 1.
  - n_terms=15: done follows edge 43.
- Handshake and input rules:
  - start while busy=1 is ignored and does not queue.
  - start high in the DONE cycle is ignored; it is accepted only once back in IDLE.
  - Changes on x and n_terms after acceptance have no effect.
- result is only updated when the engine completes. It holds its value across IDLE and the next computation's busy period until that computation's DONE.

Test Plan:
- x=0x0100, n_terms=4, start pulse -> busy=1; done pulse after edge 10; result=0x02AA (2.664); ovf=0.
- x=0x0000, n_terms=5 -> result=0x0100; ovf=0; done after edge 13.
- x=0x1234, n_terms=1 -> result=0x0100 after edge 1. Repeat with n_terms=0 -> result=0x0000 after edge 1.
- x=0x1000 (16.0), n_terms=3 -> k=2 MUL_X product=0x01000000, so ovf=1 and term wraps to 0; result=0x1100; ovf=1 at done.
- Busy-start and input changes: start x=0x0100, n_terms=4, then pulse start again with x=0x0200 at edge 4 and change n_terms -> ignored; result=0x02AA at edge 10; no second done.
- Mid-operation reset: assert rst at edge 5 of an n_terms=4 run -> result=0, busy=0, done=0, ovf=0 immediately (asynchronously). New start after release -> a normal result with correct latency.
